addr_pipe: RTL and testbench

Parametrised register-address pipeline for the RV32I core, successor to the single ID/EX address segment register. Carries source/destination register addresses, write-enables and valid bits through DEPTH back-end stages (stage 0 = EX, then MEM, WB, …). Adds per-stage hold/clear control, automatic bubble insertion, x0 write suppression, forwarding-source selection and load-use stall detection. Sits between the decoder and the hazard/forwarding logic, replacing the separate address segment registers for each stage.

---
 rtl/addr_pipe_pkg.sv | 18 +
 rtl/addr_pipe_stage.sv | 29 ++
 rtl/addr_pipe.sv | 124 ++++++++++++
 tb/tb_addr_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_pipe_pkg.sv
// Shared defaults and the stage-record layout for the register-address pipeline.
// With ADDR_PIPE_CSR_EN defined, each record also carries a CSR address and a CSR write-enable.
package addr_pipe_pkg;
   localparam int REG_AW_DEF = 5;
   localparam int CSR_AW_DEF = 12;
   localparam int FWD_NONE   = 0;

   typedef struct packed {
`ifdef ADDR_PIPE_CSR_EN
      logic [CSR_AW_DEF-1:0] csr_dest;
      logic                  csr_we;
`endif
      logic [REG_AW_DEF-1:0] dest;
      logic                  load;
      logic                  we;
      logic                  valid;
   } stage_rec_t;
endpackage

// File: rtl/addr_pipe_stage.sv
// One stage register of the address pipeline.
// Update priority at each edge: reset, then hold, then clear (flush or inserted bubble), then load.
module addr_pipe_stage
   import addr_pipe_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hold,
   input  logic         clear,
   input  logic         ins_bubble,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (hold) begin
         q <= q;
      end else if (clear || ins_bubble) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/addr_pipe.sv
// Register-address pipeline: per-stage hold/clear, bubble insertion, x0 write suppression,
// forwarding-source selection and load-use detection. ADDR_PIPE_CSR_EN adds CSR address/we fields.
module addr_pipe
   import addr_pipe_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int CSR_AW = CSR_AW_DEF,
   parameter int NSRC   = 2,
   parameter int DEPTH  = 3,
   localparam int SELW  = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DEPTH-1:0]       bubble,
   input  logic [DEPTH-1:0]       flush,
   input  logic                   valid_id,
   input  logic [NSRC*REG_AW-1:0] src_id,
   input  logic [REG_AW-1:0]      dest_id,
   input  logic                   we_id,
   input  logic                   load_id,
   output logic [NSRC*REG_AW-1:0] src_ex,
   output logic [DEPTH*REG_AW-1:0] dest_o,
   output logic [DEPTH-1:0]       we_o,
   output logic [DEPTH-1:0]       valid_o,
   output logic [NSRC*SELW-1:0]   fwd_sel,
   output logic                   load_use_stall
`ifdef ADDR_PIPE_CSR_EN
   ,
   input  logic [CSR_AW-1:0]       csr_dest_id,
   input  logic                    csr_we_id,
   output logic [DEPTH*CSR_AW-1:0] csr_dest_o,
   output logic [DEPTH-1:0]        csr_we_o
`endif
);

`ifdef ADDR_PIPE_CSR_EN
   localparam bit CSR_EN = 1'b1;
`else
   localparam bit CSR_EN = 1'b0;
`endif

   // Record layout, LSB first: valid, we, load, dest, then csr_we, csr_dest when present.
   localparam int REC_W = 3 + REG_AW + (CSR_EN ? (CSR_AW + 1) : 0);
   localparam int W0    = REC_W + NSRC * REG_AW;

   logic [W0-1:0]    s0_d;
   logic [W0-1:0]    s0_q;
   logic [REC_W-1:0] rec_q [DEPTH];
   logic             src_hit;

   // ---- ID capture into stage 0: writes to x0 and fields of non-instructions are suppressed
   assign s0_d = {src_id,
`ifdef ADDR_PIPE_CSR_EN
                  csr_dest_id,
                  csr_we_id & valid_id,
`endif
                  dest_id,
                  load_id & valid_id,
                  we_id & valid_id & (dest_id != '0),
                  valid_id};

   assign rec_q[0] = s0_q[REC_W-1:0];
   assign src_ex   = s0_q[W0-1:REC_W];

   // ---- stage registers
   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_ex
         addr_pipe_stage #(.W(W0)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .hold       (bubble[0]),
            .clear      (flush[0]),
            .ins_bubble (1'b0),
            .d          (s0_d),
            .q          (s0_q)
         );
      end else begin : g_back
         // A held upstream stage must not leak a copy of its instruction downstream.
         addr_pipe_stage #(.W(REC_W)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .hold       (bubble[k]),
            .clear      (flush[k]),
            .ins_bubble (bubble[k-1] & ~bubble[k]),
            .d          (rec_q[k-1]),
            .q          (rec_q[k])
         );
      end

      assign valid_o[k]                   = rec_q[k][0];
      assign we_o[k]                      = rec_q[k][1];
      assign dest_o[k*REG_AW +: REG_AW]   = rec_q[k][3 +: REG_AW];
`ifdef ADDR_PIPE_CSR_EN
      assign csr_we_o[k]                  = rec_q[k][3 + REG_AW];
      assign csr_dest_o[k*CSR_AW +: CSR_AW] = rec_q[k][4 + REG_AW +: CSR_AW];
`endif
   end

   // ---- forwarding select: scan oldest to youngest so the youngest producer wins
   always_comb begin
      fwd_sel = '0;
      for (int i = 0; i < NSRC; i++) begin
         fwd_sel[i*SELW +: SELW] = SELW'(FWD_NONE);
         for (int k = DEPTH - 1; k >= 1; k--) begin
            if (valid_o[k] && we_o[k] && (src_ex[i*REG_AW +: REG_AW] != '0) &&
                (dest_o[k*REG_AW +: REG_AW] == src_ex[i*REG_AW +: REG_AW])) begin
               fwd_sel[i*SELW +: SELW] = SELW'(k);
            end
         end
      end
   end

   // ---- load-use: we_o[0] already excludes x0 destinations
   always_comb begin
      src_hit = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (src_id[i*REG_AW +: REG_AW] == dest_o[REG_AW-1:0]) begin
            src_hit = 1'b1;
         end
      end
      load_use_stall = valid_id & valid_o[0] & rec_q[0][2] & we_o[0] & src_hit;
   end

endmodule

// File: tb/tb_addr_pipe.sv
// Self-checking bench for addr_pipe: directed vector table, randomized run against a
// stage-array reference model, and (with ADDR_PIPE_CSR_EN) a CSR pipelining sequence.
module tb_addr_pipe;
   localparam int REG_AW = 5;
   localparam int CSR_AW = 12;
   localparam int NSRC   = 2;
   localparam int DEPTH  = 3;
   localparam int SELW   = 2;

   logic                    clk;
   logic                    rst;
   logic [DEPTH-1:0]        bubble, flush;
   logic                    valid_id, we_id, load_id;
   logic [NSRC*REG_AW-1:0]  src_id;
   logic [REG_AW-1:0]       dest_id;
   logic [NSRC*REG_AW-1:0]  src_ex;
   logic [DEPTH*REG_AW-1:0] dest_o;
   logic [DEPTH-1:0]        we_o, valid_o;
   logic [NSRC*SELW-1:0]    fwd_sel;
   logic                    load_use_stall;
`ifdef ADDR_PIPE_CSR_EN
   logic [CSR_AW-1:0]       csr_dest_id;
   logic                    csr_we_id;
   logic [DEPTH*CSR_AW-1:0] csr_dest_o;
   logic [DEPTH-1:0]        csr_we_o;
`endif

   int n_chk = 0;
   int n_err = 0;

   addr_pipe #(.REG_AW(REG_AW), .CSR_AW(CSR_AW), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .bubble         (bubble),
      .flush          (flush),
      .valid_id       (valid_id),
      .src_id         (src_id),
      .dest_id        (dest_id),
      .we_id          (we_id),
      .load_id        (load_id),
      .src_ex         (src_ex),
      .dest_o         (dest_o),
      .we_o           (we_o),
      .valid_o        (valid_o),
      .fwd_sel        (fwd_sel),
      .load_use_stall (load_use_stall)
`ifdef ADDR_PIPE_CSR_EN
      ,
      .csr_dest_id    (csr_dest_id),
      .csr_we_id      (csr_we_id),
      .csr_dest_o     (csr_dest_o),
      .csr_we_o       (csr_we_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       rst;
      logic [2:0] bub, fl;
      logic       vid;
      logic [4:0] s0, s1, dst;
      logic       we, ld;
      logic [2:0] ev, ewe;
      logic [4:0] ed0, ed1, ed2, es0, es1;
      logic [1:0] ef0, ef1;
      logic       elus;
   } vec_t;

   function automatic vec_t mk(logic r, logic [2:0] b, logic [2:0] f, logic v,
                               logic [4:0] s0, logic [4:0] s1, logic [4:0] d, logic we, logic ld,
                               logic [2:0] ev, logic [2:0] ewe,
                               logic [4:0] ed0, logic [4:0] ed1, logic [4:0] ed2,
                               logic [4:0] es0, logic [4:0] es1,
                               logic [1:0] ef0, logic [1:0] ef1, logic elus);
      vec_t t;
      t.rst = r;  t.bub = b;  t.fl = f;  t.vid = v;  t.s0 = s0;  t.s1 = s1;  t.dst = d;
      t.we = we;  t.ld = ld;  t.ev = ev; t.ewe = ewe;
      t.ed0 = ed0; t.ed1 = ed1; t.ed2 = ed2; t.es0 = es0; t.es1 = es1;
      t.ef0 = ef0; t.ef1 = ef1; t.elus = elus;
      return t;
   endfunction

   task automatic drive(logic r, logic [2:0] b, logic [2:0] f, logic v,
                        logic [4:0] s0, logic [4:0] s1, logic [4:0] d, logic we, logic ld);
      rst = r; bubble = b; flush = f; valid_id = v;
      src_id = {s1, s0}; dest_id = d; we_id = we; load_id = ld;
   endtask

   // Reference model: one record per stage, updated from the stage rules each edge.
   logic       m_v  [DEPTH];
   logic       m_we [DEPTH];
   logic       m_ld [DEPTH];
   logic [4:0] m_d  [DEPTH];
   logic [4:0] m_s  [NSRC];

   task automatic model_edge();
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            m_v[k] = 0; m_we[k] = 0; m_ld[k] = 0; m_d[k] = 0;
         end
         for (int i = 0; i < NSRC; i++) m_s[i] = 0;
         return;
      end
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (bubble[k]) continue;
         if (flush[k] || (k > 0 && bubble[k-1])) begin
            m_v[k] = 0; m_we[k] = 0; m_ld[k] = 0; m_d[k] = 0;
            if (k == 0) for (int i = 0; i < NSRC; i++) m_s[i] = 0;
         end else if (k == 0) begin
            m_v[0]  = valid_id;
            m_we[0] = valid_id && we_id && dest_id != 0;
            m_ld[0] = valid_id && load_id;
            m_d[0]  = dest_id;
            for (int i = 0; i < NSRC; i++) m_s[i] = src_id[i*REG_AW +: REG_AW];
         end else begin
            m_v[k] = m_v[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1]; m_d[k] = m_d[k-1];
         end
      end
   endtask

   task automatic model_compare(input string tag);
      logic [2:0] ev, ewe;
      logic [14:0] ed;
      logic [9:0]  es;
      logic [3:0]  ef;
      logic        lus;
      ev = '0; ewe = '0; ed = '0; es = '0; ef = '0; lus = 0;
      for (int k = 0; k < DEPTH; k++) begin
         ev[k] = m_v[k]; ewe[k] = m_we[k]; ed[k*5 +: 5] = m_d[k];
      end
      for (int i = 0; i < NSRC; i++) begin
         int best;
         best = 0;
         es[i*5 +: 5] = m_s[i];
         for (int k = 1; k < DEPTH; k++)
            if (best == 0 && m_s[i] != 0 && m_v[k] && m_we[k] && m_d[k] == m_s[i]) best = k;
         ef[i*2 +: 2] = 2'(best);
         if (valid_id && m_v[0] && m_ld[0] && m_we[0] && src_id[i*5 +: 5] == m_d[0]) lus = 1;
      end
      chk({tag, " valid_o"}, 32'(valid_o), 32'(ev));
      chk({tag, " we_o"}, 32'(we_o), 32'(ewe));
      chk({tag, " dest_o"}, 32'(dest_o), 32'(ed));
      chk({tag, " src_ex"}, 32'(src_ex), 32'(es));
      chk({tag, " fwd_sel"}, 32'(fwd_sel), 32'(ef));
      chk({tag, " load_use_stall"}, 32'(load_use_stall), 32'(lus));
   endtask

   vec_t tv [13];

   initial begin
      //          rst bub     fl      v  s0 s1 dst we ld | ev      ewe     ed0 ed1 ed2 es0 es1 ef0 ef1 lus
      tv[0]  = mk(1, 3'b000, 3'b000, 1, 3, 4, 9,  1, 1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
      tv[1]  = mk(0, 3'b000, 3'b000, 1, 1, 2, 5,  1, 0, 3'b001, 3'b001, 5, 0, 0, 1, 2, 0, 0, 0);
      tv[2]  = mk(0, 3'b000, 3'b000, 1, 5, 5, 6,  1, 0, 3'b011, 3'b011, 6, 5, 0, 5, 5, 1, 1, 0);
      tv[3]  = mk(0, 3'b001, 3'b000, 0, 0, 0, 0,  0, 0, 3'b101, 3'b101, 6, 0, 5, 5, 5, 2, 2, 0);
      tv[4]  = mk(0, 3'b000, 3'b000, 1, 0, 0, 0,  1, 0, 3'b011, 3'b010, 0, 6, 0, 0, 0, 0, 0, 0);
      tv[5]  = mk(0, 3'b000, 3'b000, 1, 0, 0, 8,  1, 0, 3'b111, 3'b101, 8, 0, 6, 0, 0, 0, 0, 0);
      tv[6]  = mk(0, 3'b000, 3'b000, 1, 1, 0, 7,  1, 1, 3'b111, 3'b011, 7, 8, 0, 1, 0, 0, 0, 0);
      tv[7]  = mk(0, 3'b001, 3'b000, 1, 7, 2, 9,  1, 0, 3'b101, 3'b101, 7, 0, 8, 1, 0, 0, 0, 1);
      tv[8]  = mk(0, 3'b000, 3'b000, 1, 7, 2, 9,  1, 0, 3'b011, 3'b011, 9, 7, 0, 7, 2, 1, 0, 0);
      tv[9]  = mk(0, 3'b010, 3'b010, 0, 0, 0, 0,  0, 0, 3'b010, 3'b010, 0, 7, 0, 0, 0, 0, 0, 0);
      tv[10] = mk(0, 3'b000, 3'b001, 1, 7, 0, 10, 1, 0, 3'b100, 3'b100, 0, 0, 7, 0, 0, 0, 0, 0);
      tv[11] = mk(0, 3'b111, 3'b000, 1, 3, 3, 12, 1, 0, 3'b100, 3'b100, 0, 0, 7, 0, 0, 0, 0, 0);
      tv[12] = mk(1, 3'b111, 3'b111, 1, 3, 3, 12, 1, 1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef ADDR_PIPE_CSR_EN
      csr_dest_id = '0; csr_we_id = 0;
`endif
      drive(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

      // ---- directed table
      for (int n = 0; n < 13; n++) begin
         string tag;
         tag = $sformatf("vec%0d", n);
         drive(tv[n].rst, tv[n].bub, tv[n].fl, tv[n].vid, tv[n].s0, tv[n].s1, tv[n].dst,
               tv[n].we, tv[n].ld);
         @(posedge clk);
         @(negedge clk);
         chk({tag, " valid_o"}, 32'(valid_o), 32'(tv[n].ev));
         chk({tag, " we_o"}, 32'(we_o), 32'(tv[n].ewe));
         chk({tag, " dest_o"}, 32'(dest_o), 32'({tv[n].ed2, tv[n].ed1, tv[n].ed0}));
         chk({tag, " src_ex"}, 32'(src_ex), 32'({tv[n].es1, tv[n].es0}));
         chk({tag, " fwd_sel"}, 32'(fwd_sel), 32'({tv[n].ef1, tv[n].ef0}));
         chk({tag, " load_use_stall"}, 32'(load_use_stall), 32'(tv[n].elus));
      end

`ifdef ADDR_PIPE_CSR_EN
      // ---- CSR address travels three edges to stage 2; a flush on stage 1 wipes it
      drive(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
      @(posedge clk); @(negedge clk);
      drive(0, 3'b000, 3'b000, 1, 0, 0, 3, 1, 0);
      csr_dest_id = 12'h300; csr_we_id = 1;
      @(posedge clk); @(negedge clk);
      drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
      csr_dest_id = '0; csr_we_id = 0;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      chk("csr stage2 dest", 32'(csr_dest_o[2*CSR_AW +: CSR_AW]), 32'h300);
      chk("csr stage2 we", 32'(csr_we_o[2]), 32'd1);
      drive(0, 3'b000, 3'b000, 1, 0, 0, 3, 1, 0);
      csr_dest_id = 12'h300; csr_we_id = 1;
      @(posedge clk); @(negedge clk);
      drive(0, 3'b000, 3'b010, 0, 0, 0, 0, 0, 0);
      csr_dest_id = '0; csr_we_id = 0;
      @(posedge clk); @(negedge clk);
      chk("csr stage1 flushed", 32'({csr_we_o[1], csr_dest_o[CSR_AW +: CSR_AW]}), 32'd0);
      drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
      @(posedge clk); @(negedge clk);
      chk("csr stage2 flushed", 32'({csr_we_o[2], csr_dest_o[2*CSR_AW +: CSR_AW]}), 32'd0);
`endif

      // ---- randomized run against the reference model
      drive(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      model_compare("rand reset");
      for (int c = 0; c < 400; c++) begin
         logic [2:0] b, f;
         for (int k = 0; k < DEPTH; k++) begin
            b[k] = ($urandom_range(3) == 0);
            f[k] = ($urandom_range(7) == 0);
         end
         drive(($urandom_range(49) == 0), b, f, 1'($urandom), 5'($urandom_range(3)),
               5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom), 1'($urandom));
         @(posedge clk);
         model_edge();
         @(negedge clk);
         model_compare($sformatf("rand%0d", c));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
